// File: rtl/aes_pkg.sv
// aes_pkg: shared AES byte-level definitions.
//   AES_POLY   - reduction term XORed in on carry-out of bit 7 (x^8 = x^4+x^3+x+1)
//   AFF_FWD_C  - additive constant of the forward affine transform
//   AFF_INV_C  - additive constant of the inverse affine transform
//   STEP_LAST  - last square/multiply iteration of the a^254 loop
//   sbox_state_t - control states of the sequential S-box
//   affine_fwd / affine_inv - the AES affine transforms over GF(2)
package aes_pkg;

    localparam logic [7:0] AES_POLY  = 8'h1b;
    localparam logic [7:0] AFF_FWD_C = 8'h63;
    localparam logic [7:0] AFF_INV_C = 8'h05;
    localparam logic [2:0] STEP_LAST = 3'd7;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SQ   = 3'd1,
        MUL  = 3'd2,
        AFF  = 3'd3,
        DONE = 3'd4
    } sbox_state_t;

    // Forward affine: bit i = x[i]^x[i+4]^x[i+5]^x[i+6]^x[i+7]^c[i] (indices mod 8).
    function automatic logic [7:0] affine_fwd(input logic [7:0] x);
        logic [7:0] y;
        for (int i = 0; i < 8; i++) begin
            y[i] = x[i] ^ x[(i + 4) % 8] ^ x[(i + 5) % 8] ^ x[(i + 6) % 8]
                 ^ x[(i + 7) % 8] ^ AFF_FWD_C[i];
        end
        return y;
    endfunction

    // Inverse affine: rotl(x,1) ^ rotl(x,3) ^ rotl(x,6) ^ c, i.e.
    // bit i = x[i+7]^x[i+5]^x[i+2]^c[i] (indices mod 8).
    function automatic logic [7:0] affine_inv(input logic [7:0] x);
        logic [7:0] y;
        for (int i = 0; i < 8; i++) begin
            y[i] = x[(i + 7) % 8] ^ x[(i + 5) % 8] ^ x[(i + 2) % 8] ^ AFF_INV_C[i];
        end
        return y;
    endfunction

endpackage

// File: rtl/gf256_mul.sv
// gf256_mul: combinational GF(2^8) multiplier, AES polynomial 0x11b.
// Shift-and-add: partial product accumulates a*x^i for every set bit of b;
// a*x^i is formed by a left shift with reduction on carry-out of bit 7.
//   a  in  8  multiplicand
//   b  in  8  multiplier
//   p  out 8  a*b mod 0x11b
module gf256_mul
    import aes_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);

    // xt[i] = a * x^i (reduced); pp[i] = sum of terms for bits below i
    logic [7:0] xt [0:7];
    logic [7:0] pp [0:8];

    assign xt[0] = a;
    assign pp[0] = 8'h00;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_term
            assign pp[gi + 1] = pp[gi] ^ (b[gi] ? xt[gi] : 8'h00);
            if (gi < 7) begin : g_xtime
                assign xt[gi + 1] = {xt[gi][6:0], 1'b0} ^ (xt[gi][7] ? AES_POLY : 8'h00);
            end
        end
    endgenerate

    assign p = pp[8];

endmodule

// File: rtl/sbox_fwd_seq.sv
// sbox_fwd_seq: sequential AES SubBytes S-box.
// The inverse is computed as a^254 by square-and-multiply, then the forward
// affine transform is applied. Latency is fixed: 15 edges from acceptance to
// out_valid with PAR_MUL=0 (one shared multiplier, alternating SQ/MUL), 8 with
// PAR_MUL=1 (square and multiply in the same cycle). One byte in flight.
// Optional build macro SBOX_INV_MODE_EN adds inv_i for the inverse S-box.
//   clk        in  1  rising-edge clock
//   rst        in  1  synchronous active-high reset
//   in_valid   in  1  input byte valid
//   in_ready   out 1  block can accept a byte (IDLE only)
//   in_data    in  8  byte to substitute
//   out_valid  out 1  result valid (DONE)
//   out_ready  in  1  downstream accepts result
//   out_data   out 8  S(in_data), held while stalled
//   inv_i      in  1  (SBOX_INV_MODE_EN only) inverse S-box, sampled at acceptance
module sbox_fwd_seq
    import aes_pkg::*;
#(
    parameter int PAR_MUL = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
`ifdef SBOX_INV_MODE_EN
    input  logic       inv_i,
`endif
    output logic [7:0] out_data
);

    sbox_state_t state_reg, state_next;
    logic [7:0]  sq_reg, sq_next;
    logic [7:0]  acc_reg, acc_next;
    logic [2:0]  step_reg, step_next;
    logic [7:0]  out_data_reg, out_data_next;

    // Byte loaded into sq on acceptance and value written in AFF.
    logic [7:0]  load_byte;
    logic [7:0]  aff_result;

`ifdef SBOX_INV_MODE_EN
    logic inv_reg, inv_next;

    // Inverse mode undoes the affine map first, so the exponentiation
    // yields the original byte directly and AFF becomes a pass-through.
    assign load_byte  = inv_i ? affine_inv(in_data) : in_data;
    assign aff_result = inv_reg ? acc_reg : affine_fwd(acc_reg);
`else
    assign load_byte  = in_data;
    assign aff_result = affine_fwd(acc_reg);
`endif

    // sq_sq  : sq*sq          (new square)
    // acc_mul: accumulator product for the current step
    logic [7:0] sq_sq;
    logic [7:0] acc_mul;

    generate
        if (PAR_MUL != 0) begin : g_par
            // acc * sq^2 chained behind the squarer in one cycle
            gf256_mul u_sq  (.a(sq_reg),  .b(sq_reg), .p(sq_sq));
            gf256_mul u_mul (.a(acc_reg), .b(sq_sq),  .p(acc_mul));
        end else begin : g_shared
            // One multiplier: sq*sq in SQ, acc*sq in MUL (sq already squared)
            logic [7:0] op_a;
            logic [7:0] prod;
            assign op_a = (state_reg == MUL) ? acc_reg : sq_reg;
            gf256_mul u_mul (.a(op_a), .b(sq_reg), .p(prod));
            assign sq_sq   = prod;
            assign acc_mul = prod;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            sq_reg       <= 8'h00;
            acc_reg      <= 8'h00;
            step_reg     <= 3'd0;
            out_data_reg <= 8'h00;
`ifdef SBOX_INV_MODE_EN
            inv_reg      <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            sq_reg       <= sq_next;
            acc_reg      <= acc_next;
            step_reg     <= step_next;
            out_data_reg <= out_data_next;
`ifdef SBOX_INV_MODE_EN
            inv_reg      <= inv_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        sq_next       = sq_reg;
        acc_next      = acc_reg;
        step_next     = step_reg;
        out_data_next = out_data_reg;
`ifdef SBOX_INV_MODE_EN
        inv_next      = inv_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    sq_next    = load_byte;
                    acc_next   = 8'h01;
                    step_next  = 3'd1;
                    state_next = SQ;
`ifdef SBOX_INV_MODE_EN
                    inv_next   = inv_i;
`endif
                end
            end
            SQ: begin
                sq_next = sq_sq;
                if (PAR_MUL != 0) begin
                    acc_next = acc_mul;
                    // step saturates at 7; the loop exits instead of wrapping
                    if (step_reg == STEP_LAST) begin
                        state_next = AFF;
                    end else begin
                        step_next = step_reg + 3'd1;
                    end
                end else begin
                    state_next = MUL;
                end
            end
            MUL: begin
                acc_next = acc_mul;
                if (step_reg == STEP_LAST) begin
                    state_next = AFF;
                end else begin
                    step_next  = step_reg + 3'd1;
                    state_next = SQ;
                end
            end
            AFF: begin
                out_data_next = aff_result;
                state_next    = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign out_data  = out_data_reg;

endmodule

// File: tb/tb_sbox_fwd_seq.sv
// tb_sbox_fwd_seq: self-checking bench for sbox_fwd_seq.
// Two instances: index 0 is PAR_MUL=0 (latency 15), index 1 is PAR_MUL=1
// (latency 8). Expected bytes come from the FIPS-197 S-box table and are
// queued at acceptance; a monitor per instance pops and compares on each
// output transfer.
module tb_sbox_fwd_seq;

    logic       clk;
    logic       rst;
    logic [1:0] in_valid;
    logic [1:0] in_ready;
    logic [1:0] out_valid;
    logic [1:0] out_ready;
    logic [7:0] in_data  [2];
    logic [7:0] out_data [2];
`ifdef SBOX_INV_MODE_EN
    logic [1:0] inv_s;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q0 [$];
    logic [7:0] exp_q1 [$];

    logic [0:255][7:0] sbox_tbl = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    sbox_fwd_seq #(.PAR_MUL(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .in_data   (in_data[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
`ifdef SBOX_INV_MODE_EN
        .inv_i     (inv_s[0]),
`endif
        .out_data  (out_data[0])
    );

    sbox_fwd_seq #(.PAR_MUL(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .in_data   (in_data[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
`ifdef SBOX_INV_MODE_EN
        .inv_i     (inv_s[1]),
`endif
        .out_data  (out_data[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitors: a transfer happens on the edge after a negedge
    // that sees valid & ready, so each such negedge pops one entry.
    always @(negedge clk) begin
        logic [7:0] e0;
        if (!rst && out_valid[0] && out_ready[0]) begin
            checks++;
            if (exp_q0.size() == 0) begin
                errors++;
                $display("FAIL out0_unexpected got=%02h required=none", out_data[0]);
            end else begin
                e0 = exp_q0.pop_front();
                if (out_data[0] !== e0) begin
                    errors++;
                    $display("FAIL out0_data got=%02h required=%02h", out_data[0], e0);
                end else begin
                    $display("dut0 out %02h ok", out_data[0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] e1;
        if (!rst && out_valid[1] && out_ready[1]) begin
            checks++;
            if (exp_q1.size() == 0) begin
                errors++;
                $display("FAIL out1_unexpected got=%02h required=none", out_data[1]);
            end else begin
                e1 = exp_q1.pop_front();
                if (out_data[1] !== e1) begin
                    errors++;
                    $display("FAIL out1_data got=%02h required=%02h", out_data[1], e1);
                end
            end
        end
    end

    function automatic logic [7:0] inv_lookup(input logic [7:0] v);
        logic [7:0] r;
        r = 8'h00;
        for (int j = 0; j < 256; j++) begin
            if (sbox_tbl[j] == v) r = 8'(j);
        end
        return r;
    endfunction

    // Offer one byte to instance d; returns just after the acceptance edge.
    task automatic send(input int d, input logic [7:0] v, input bit inv, input bit push);
        int n;
        logic [7:0] e;
        n = 0;
        @(negedge clk);
        while (!in_ready[d] && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready[d]) begin
            errors++;
            $display("FAIL accept_timeout dut%0d got in_ready=0 required=1", d);
            return;
        end
        in_valid[d] = 1'b1;
        in_data[d]  = v;
`ifdef SBOX_INV_MODE_EN
        inv_s[d]    = inv;
`endif
        e = inv ? inv_lookup(v) : sbox_tbl[v];
        if (push) begin
            if (d == 0) exp_q0.push_back(e);
            else        exp_q1.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        in_data[d]  = 8'($urandom);
`ifdef SBOX_INV_MODE_EN
        inv_s[d]    = 1'($urandom);
`endif
    endtask

    // Count edges from acceptance until out_valid; check latency and that
    // in_ready stays low while busy.
    task automatic wait_out(input int d, input int lat);
        int n;
        bit busy_bad;
        n = 0;
        busy_bad = 1'b0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (!out_valid[d] && in_ready[d]) busy_bad = 1'b1;
        end while (!out_valid[d] && n < 60);
        checks++;
        if (n != lat || !out_valid[d]) begin
            errors++;
            $display("FAIL latency dut%0d got=%0d required=%0d", d, n, lat);
        end
        checks++;
        if (busy_bad) begin
            errors++;
            $display("FAIL busy_in_ready dut%0d got in_ready=1 while busy required=0", d);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || out_data[d] !== 8'h00) begin
                errors++;
                $display("FAIL reset dut%0d got rdy=%b vld=%b data=%02h required 1 0 00",
                         d, in_ready[d], out_valid[d], out_data[d]);
            end
        end
        $display("reset state checked");
    endtask

    task automatic test_zero();
        send(0, 8'h00, 1'b0, 1'b1);
        wait_out(0, 15);
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [4];
        vals = '{8'h01, 8'h53, 8'h52, 8'hff};
        for (int i = 0; i < 4; i++) begin
            send(0, vals[i], 1'b0, 1'b1);
            wait_out(0, 15);
        end
    endtask

    task automatic test_sweep();
        for (int d = 0; d < 2; d++) begin
            for (int v = 0; v < 256; v++) begin
                send(d, 8'(v), 1'b0, 1'b1);
                wait_out(d, (d == 0) ? 15 : 8);
            end
            $display("sweep dut%0d done", d);
        end
    endtask

    task automatic test_stall();
        out_ready[0] = 1'b0;
        send(0, 8'h10, 1'b0, 1'b1);
        wait_out(0, 15);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            in_valid[0] = 1'b1;
            in_data[0]  = 8'($urandom);
            @(negedge clk);
            checks++;
            if (out_valid[0] !== 1'b1 || out_data[0] !== 8'hca || in_ready[0] !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d got vld=%b data=%02h rdy=%b required 1 ca 0",
                         k, out_valid[0], out_data[0], in_ready[0]);
            end
        end
        @(posedge clk);
        #1;
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL stall_release got vld=%b rdy=%b required 0 1", out_valid[0], in_ready[0]);
        end
        // ignored pulses must not produce any output
        repeat (20) @(negedge clk);
        checks++;
        if (out_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL stall_ghost got out_valid=%b required=0", out_valid[0]);
        end
    endtask

    task automatic test_reset_mid();
        bit ghost;
        send(0, 8'h37, 1'b0, 1'b0);
        // six edges after acceptance the loop is in SQ with step 4
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got rdy=%b vld=%b required 1 0", in_ready[0], out_valid[0]);
        end
        ghost = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid[0]) ghost = 1'b1;
        end
        checks++;
        if (ghost) begin
            errors++;
            $display("FAIL reset_mid_ghost got out_valid=1 required=0");
        end
        send(0, 8'h53, 1'b0, 1'b1);
        wait_out(0, 15);
    endtask

`ifdef SBOX_INV_MODE_EN
    task automatic test_inv();
        logic [7:0] vals [3];
        vals = '{8'hed, 8'h63, 8'h16};
        for (int i = 0; i < 3; i++) begin
            send(0, vals[i], 1'b1, 1'b1);
            wait_out(0, 15);
            send(1, vals[i], 1'b1, 1'b1);
            wait_out(1, 8);
        end
    endtask
`endif

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 2'b00;
        out_ready = 2'b11;
        in_data[0] = 8'h00;
        in_data[1] = 8'h00;
`ifdef SBOX_INV_MODE_EN
        inv_s = 2'b00;
`endif
        test_reset();
        test_zero();
        test_back_to_back();
        test_sweep();
        test_stall();
        test_reset_mid();
`ifdef SBOX_INV_MODE_EN
        test_inv();
`endif
        n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            errors++;
            $display("FAIL drain got pending=%0d/%0d required=0/0", exp_q0.size(), exp_q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
